// File: rtl/display_register_queue.sv
// Queues CPU display-register writes and replays them to the display controller
// only during vertical blank; also counts frames and latches per-frame collision flags.
module display_register_queue #(
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_write_i,
  input  logic [11:0] cpu_index_i,
  input  logic [15:0] cpu_value_i,
  input  logic        cpu_flush_i,
  output logic        queue_full_o,
  output logic        queue_empty_o,
  output logic        overflow_o,
  input  logic        in_vblank_i,
  input  logic [5:0]  collision_i,
  output logic        register_write_o,
  output logic [11:0] register_index_o,
  output logic [15:0] register_write_value_o,
  output logic [5:0]  collision_status_o,
  output logic [15:0] frame_count_o
);

  localparam int ENTRY_W = 28;
  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 vblank_q;
  logic                 rise_q;
  logic [15:0]          frame_q;
  logic [5:0]           coll_q;
  logic                 wr_q;
  logic [11:0]          idx_q;
  logic [15:0]          val_q;

  logic vblank_rise;
  logic full;
  logic empty;
  logic pop;
  logic push;

  assign vblank_rise = in_vblank_i & ~vblank_q;
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pop        = 1'b0;
    push       = 1'b0;
    if (cpu_flush_i) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:    pop = vblank_rise & ~empty;
        DRAIN:   pop = in_vblank_i & ~empty;
        default: pop = 1'b0;
      endcase
      // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
      push = cpu_write_i & (~full | pop);
      if (cpu_write_i & full & ~pop) overflow_d = 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (push & ~pop)      count_d = count_q + COUNT_ONE;
      else if (pop & ~push) count_d = count_q - COUNT_ONE;
      state_d = (pop && count_d != '0) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      vblank_q   <= 1'b0;
      rise_q     <= 1'b0;
      frame_q    <= '0;
      coll_q     <= '0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      val_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      vblank_q   <= in_vblank_i;
      rise_q     <= vblank_rise;
      if (vblank_rise) frame_q <= frame_q + 16'd1;
      // Controller refreshes its flags on the rise edge, so sample one cycle later.
      if (rise_q) coll_q <= collision_i;
      wr_q <= pop;
      if (pop) {idx_q, val_q} <= mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cpu_index_i, cpu_value_i};
  end

  assign queue_full_o           = full;
  assign queue_empty_o          = empty;
  assign overflow_o             = overflow_q;
  assign register_write_o       = wr_q;
  assign register_index_o       = idx_q;
  assign register_write_value_o = val_q;
  assign collision_status_o     = coll_q;
  assign frame_count_o          = frame_q;

endmodule

// File: tb/tb_display_register_queue.sv
// Self-checking bench for display_register_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_display_register_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_write_i = 1'b0;
  logic [11:0] cpu_index_i = '0;
  logic [15:0] cpu_value_i = '0;
  logic        cpu_flush_i = 1'b0;
  logic        in_vblank_i = 1'b0;
  logic [5:0]  collision_i = '0;
  logic        queue_full_o, queue_empty_o, overflow_o;
  logic        register_write_o;
  logic [11:0] register_index_o;
  logic [15:0] register_write_value_o;
  logic [5:0]  collision_status_o;
  logic [15:0] frame_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [27:0] mq[$];
  bit          m_drain, m_vbp, m_risep, m_ovf, m_wr;
  logic [11:0] m_idx;
  logic [15:0] m_val;
  logic [5:0]  m_coll;
  logic [15:0] m_frame;

  display_register_queue #(.FIFO_DEPTH(16), .PTR_WIDTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cpu_write_i            (cpu_write_i),
    .cpu_index_i            (cpu_index_i),
    .cpu_value_i            (cpu_value_i),
    .cpu_flush_i            (cpu_flush_i),
    .queue_full_o           (queue_full_o),
    .queue_empty_o          (queue_empty_o),
    .overflow_o             (overflow_o),
    .in_vblank_i            (in_vblank_i),
    .collision_i            (collision_i),
    .register_write_o       (register_write_o),
    .register_index_o       (register_index_o),
    .register_write_value_o (register_write_value_o),
    .collision_status_o     (collision_status_o),
    .frame_count_o          (frame_count_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_drain = 0; m_vbp = 0; m_risep = 0; m_ovf = 0; m_wr = 0;
    m_idx = '0; m_val = '0; m_coll = '0; m_frame = '0;
  endtask

  // Advance one clock edge: model computes what that edge should do from the
  // current inputs, then the DUT outputs are observed 1 time unit after the edge.
  task automatic tick();
    bit rise;
    bit send;
    logic [27:0] head;
    rise = in_vblank_i && !m_vbp;
    if (m_risep) m_coll = collision_i;
    if (rise) m_frame = m_frame + 16'd1;
    m_wr = 1'b0;
    if (cpu_flush_i) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drain = 1'b0;
    end else begin
      send = (m_drain ? bit'(in_vblank_i) : rise) && (mq.size() > 0);
      if (send) begin
        head  = mq.pop_front();
        m_wr  = 1'b1;
        m_idx = head[27:16];
        m_val = head[15:0];
      end
      if (cpu_write_i) begin
        if (mq.size() < DEPTH) mq.push_back({cpu_index_i, cpu_value_i});
        else m_ovf = 1'b1;
      end
      m_drain = send && (mq.size() > 0);
    end
    m_risep = rise;
    m_vbp   = in_vblank_i;
    @(posedge clk);
    #1;
    if (register_write_o)
      $display("strobe idx=%03h val=%04h frame=%0d", register_index_o, register_write_value_o, frame_count_o);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({register_write_o, register_index_o, register_write_value_o, collision_status_o, frame_count_o,
         queue_full_o, queue_empty_o, overflow_o} !== {1'b0, 12'h0, 16'h0, 6'h0, 16'h0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got wr=%b idx=%h val=%h coll=%h frame=%h full=%b empty=%b ovf=%b expected all 0, empty=1",
               register_write_o, register_index_o, register_write_value_o, collision_status_o, frame_count_o,
               queue_full_o, queue_empty_o, overflow_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic_drain();
    logic [11:0] want [3];
    int got;
    want[0] = 12'd3; want[1] = 12'd7; want[2] = 12'd11;
    got = 0;
    in_vblank_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_write_i = 1'b1; cpu_index_i = want[i]; cpu_value_i = 16'($urandom);
      tick();
      n_checks++;
      if (register_write_o !== 1'b0) begin
        n_fail++; $display("FAIL basic_no_strobe_outside_vblank: got %b expected 0", register_write_o);
      end
    end
    cpu_write_i = 1'b0;
    in_vblank_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({register_write_o, register_index_o, register_write_value_o} !== {m_wr, m_idx, m_val}) begin
        n_fail++;
        $display("FAIL basic_strobe: got %b/%h/%h expected %b/%h/%h", register_write_o, register_index_o,
                 register_write_value_o, m_wr, m_idx, m_val);
      end
      if (register_write_o === 1'b1) begin
        n_checks++;
        if (got >= 3 || c != got || register_index_o !== want[got]) begin
          n_fail++;
          $display("FAIL basic_order: cycle %0d got idx %h expected strobe %0d at cycle %0d", c, register_index_o, got, got);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 3 || queue_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_count: got %0d strobes empty=%b expected 3 strobes empty=1", got, queue_empty_o);
    end
    in_vblank_i = 1'b0;
    tick();
  endtask

  task automatic test_overflow_flush();
    int got;
    got = 0;
    in_vblank_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_write_i = 1'b1; cpu_index_i = 12'($urandom_range(0, 12'h7FF)); cpu_value_i = 16'($urandom);
      tick();
    end
    n_checks++;
    if ({queue_full_o, queue_empty_o, overflow_o} !== 3'b100) begin
      n_fail++; $display("FAIL ovf_full16: got full/empty/ovf=%b expected 100", {queue_full_o, queue_empty_o, overflow_o});
    end
    cpu_index_i = 12'hABC; cpu_value_i = 16'hDEAD;
    tick();
    n_checks++;
    if ({queue_full_o, overflow_o} !== 2'b11 || m_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_17th: got full/ovf=%b expected 11", {queue_full_o, overflow_o});
    end
    cpu_write_i = 1'b0;
    in_vblank_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_checks++;
      if ({register_write_o, register_index_o, register_write_value_o} !== {m_wr, m_idx, m_val} ||
          (register_write_o === 1'b1 && register_index_o === 12'hABC)) begin
        n_fail++;
        $display("FAIL ovf_drain: got %b/%h/%h expected %b/%h/%h", register_write_o, register_index_o,
                 register_write_value_o, m_wr, m_idx, m_val);
      end
      if (register_write_o === 1'b1) got++;
    end
    in_vblank_i = 1'b0;
    tick();
    n_checks++;
    if (got != DEPTH || overflow_o !== 1'b1 || queue_empty_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %0d strobes ovf=%b empty=%b expected 16 strobes ovf=1 empty=1",
                         got, overflow_o, queue_empty_o);
    end
    cpu_write_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cpu_index_i = 12'($urandom); cpu_value_i = 16'($urandom);
      tick();
    end
    cpu_flush_i = 1'b1;
    tick();
    n_checks++;
    if ({queue_full_o, queue_empty_o, overflow_o} !== 3'b010 || mq.size() != 0) begin
      n_fail++; $display("FAIL flush: got full/empty/ovf=%b expected 010", {queue_full_o, queue_empty_o, overflow_o});
    end
    cpu_flush_i = 1'b0; cpu_write_i = 1'b0;
    tick();
  endtask

  task automatic test_partial_vblank();
    int got;
    in_vblank_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cpu_write_i = 1'b1; cpu_index_i = 12'(i + 32); cpu_value_i = 16'($urandom);
      tick();
    end
    cpu_write_i = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      got = 0;
      for (int c = 0; c < 12; c++) begin
        in_vblank_i = (pass == 0) ? (c < 4) : (c < 9);
        tick();
        n_checks++;
        if ({register_write_o, register_index_o, register_write_value_o} !== {m_wr, m_idx, m_val}) begin
          n_fail++;
          $display("FAIL partial_strobe: got %b/%h/%h expected %b/%h/%h", register_write_o, register_index_o,
                   register_write_value_o, m_wr, m_idx, m_val);
        end
        if (register_write_o === 1'b1) got++;
      end
      n_checks++;
      if (got != ((pass == 0) ? 4 : 6)) begin
        n_fail++; $display("FAIL partial_count: pass %0d got %0d strobes expected %0d", pass, got, (pass == 0) ? 4 : 6);
      end
    end
  endtask

  task automatic test_push_during_drain();
    int got;
    got = 0;
    in_vblank_i = 1'b0;
    cpu_write_i = 1'b1; cpu_index_i = 12'h100; cpu_value_i = 16'h1234;
    tick();
    in_vblank_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cpu_index_i = 12'(12'h101 + c); cpu_value_i = 16'($urandom);
      tick();
      n_checks++;
      if ({register_write_o, register_index_o, register_write_value_o} !== {m_wr, m_idx, m_val} ||
          queue_empty_o !== 1'b0 || queue_full_o !== 1'b0 || mq.size() != 1) begin
        n_fail++;
        $display("FAIL pushpop_strobe: got %b/%h/%h empty=%b expected %b/%h/%h empty=0", register_write_o,
                 register_index_o, register_write_value_o, queue_empty_o, m_wr, m_idx, m_val);
      end
      if (register_write_o === 1'b1) got++;
    end
    cpu_write_i = 1'b0;
    in_vblank_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (register_write_o === 1'b1) got++;
    end
    n_checks++;
    if (got != 6 || queue_empty_o !== 1'b0) begin
      n_fail++; $display("FAIL pushpop_count: got %0d strobes empty=%b expected 6 strobes empty=0", got, queue_empty_o);
    end
    cpu_flush_i = 1'b1;
    tick();
    cpu_flush_i = 1'b0;
  endtask

  task automatic test_collision_frames();
    logic [15:0] f0;
    in_vblank_i = 1'b0;
    tick();
    f0 = m_frame;
    in_vblank_i = 1'b1; collision_i = 6'b010010;
    tick();
    collision_i = 6'b100001;
    tick();
    in_vblank_i = 1'b0; collision_i = 6'b000110;
    tick();
    n_checks++;
    if (collision_status_o !== 6'b100001 || m_coll !== 6'b100001) begin
      n_fail++; $display("FAIL collision_capture: got %b expected 100001", collision_status_o);
    end
    for (int p = 0; p < 3; p++) begin
      in_vblank_i = 1'b1; tick();
      in_vblank_i = 1'b0; tick();
    end
    n_checks++;
    if (frame_count_o !== f0 + 16'd4 || frame_count_o !== m_frame) begin
      n_fail++; $display("FAIL frame_count: got %h expected %h", frame_count_o, f0 + 16'd4);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cpu_write_i = ($urandom_range(0, 99) < 55);
      cpu_index_i = 12'($urandom);
      cpu_value_i = 16'($urandom);
      cpu_flush_i = ($urandom_range(0, 99) < 2);
      collision_i = 6'($urandom);
      if ($urandom_range(0, 5) == 0) in_vblank_i = ~in_vblank_i;
      tick();
      n_checks++;
      if ({register_write_o, register_index_o, register_write_value_o} !== {m_wr, m_idx, m_val}) begin
        n_fail++;
        $display("FAIL random_strobe: cycle %0d got %b/%h/%h expected %b/%h/%h", c, register_write_o,
                 register_index_o, register_write_value_o, m_wr, m_idx, m_val);
      end
      n_checks++;
      if ({queue_full_o, queue_empty_o, overflow_o, collision_status_o, frame_count_o} !==
          {mq.size() == DEPTH, mq.size() == 0, m_ovf, m_coll, m_frame}) begin
        n_fail++;
        $display("FAIL random_status: cycle %0d got full/empty/ovf=%b coll=%h frame=%h expected %b coll=%h frame=%h",
                 c, {queue_full_o, queue_empty_o, overflow_o}, collision_status_o, frame_count_o,
                 {mq.size() == DEPTH, mq.size() == 0, m_ovf}, m_coll, m_frame);
      end
    end
    cpu_write_i = 1'b0; in_vblank_i = 1'b0; cpu_flush_i = 1'b1;
    tick();
    cpu_flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    in_vblank_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_write_i = 1'b1; cpu_index_i = 12'(i + 12'h200); cpu_value_i = 16'($urandom);
      tick();
    end
    cpu_write_i = 1'b0;
    in_vblank_i = 1'b1;
    tick();
    tick();
    n_checks++;
    if (register_write_o !== 1'b1 || m_wr !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_precondition: got wr=%b expected 1", register_write_o);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({register_write_o, queue_empty_o, queue_full_o, overflow_o, frame_count_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL rst_mid_drain: got wr=%b empty=%b full=%b ovf=%b frame=%h expected wr=0 empty=1 full=0 ovf=0 frame=0",
                         register_write_o, queue_empty_o, queue_full_o, overflow_o, frame_count_o);
    end
    @(posedge clk);
    #1;
    in_vblank_i = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({register_write_o, queue_empty_o} !== 2'b01) begin
        n_fail++; $display("FAIL rst_after: got wr/empty=%b expected 01", {register_write_o, queue_empty_o});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_drain();
    test_overflow_flush();
    test_partial_vblank();
    test_push_during_drain();
    test_collision_frames();
    test_random();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
